// File: rtl/wb_commit_pkg.sv
// Shared write-back / commit encodings reused by the pipeline-register blocks.
package wb_commit_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC2 = 2'b10,
    WB_LHI = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    Z_NONE = 2'b00,
    Z_ALU  = 2'b01,
    Z_MEM  = 2'b10
  } z_sel_e;

  localparam logic [15:0] PC_BUBBLE = 16'hb000;

  function automatic logic [15:0] lhi_value(input logic [8:0] imm);
    return {imm, 7'b000_0000};
  endfunction

endpackage

// File: rtl/wb_commit_reg_file.sv
// 8x16 architectural register file: one write port, two write-through read ports.
module reg_file_8x16
  import wb_commit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd,
  input  logic [2:0]  ra_addr,
  input  logic [2:0]  rb_addr,
  output logic [15:0] ra_data,
  output logic [15:0] rb_data
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  // next register contents
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[wa] = wd;
    end else begin
      regs_d[wa] = regs_q[wa];
    end
  end

  // register storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // read port A, newest value wins
  always_comb begin
    if (we && (ra_addr == wa)) begin
      ra_data = wd;
    end else begin
      ra_data = regs_q[ra_addr];
    end
  end

  // read port B, newest value wins
  always_comb begin
    if (we && (rb_addr == wa)) begin
      rb_data = wd;
    end else begin
      rb_data = regs_q[rb_addr];
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Write-back / commit stage: selects the write-back value, owns the register
// file, C/Z flags, retire counter and commit trace.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      dm_data,
  input  logic [15:0]      PC_plus_2,
  input  logic [15:0]      alu_out,
  input  logic [15:0]      PC,
  input  logic [15:0]      mem_data,
  input  logic [15:0]      mem_addr,
  input  logic [8:0]       Imm2,
  input  logic [1:0]       MemtoReg,
  input  logic [2:0]       RD,
  input  logic             L,
  input  logic             S,
  input  logic             RegWrite,
  input  logic             CWrite,
  input  logic             carry,
  input  logic             invalid1,
  input  logic [1:0]       ZWrite,
  input  logic [2:0]       ra_addr,
  input  logic [2:0]       rb_addr,
  output logic [15:0]      ra_data,
  output logic [15:0]      rb_data,
  output logic             wb_valid,
  output logic [2:0]       wb_rd,
  output logic [15:0]      wb_data,
  output logic             c_flag,
  output logic             z_flag,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [15:0]      commit_pc,
  output logic             commit_store,
  output logic [15:0]      commit_addr,
  output logic [15:0]      commit_sdata
);

  logic             commit_s;
  logic [15:0]      wb_data_s;
  logic             c_flag_q, c_flag_d;
  logic             z_flag_q, z_flag_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [15:0]      commit_pc_q, commit_pc_d;
  logic             commit_store_q, commit_store_d;
  logic [15:0]      commit_addr_q, commit_addr_d;
  logic [15:0]      commit_sdata_q, commit_sdata_d;

  // L only matters through MemtoReg, so it is deliberately unused here
  logic unused_s;
  assign unused_s = L;

  assign commit_s = ~invalid1;

  // write-back source select
  always_comb begin
    case (MemtoReg)
      WB_ALU:  wb_data_s = alu_out;
      WB_MEM:  wb_data_s = dm_data;
      WB_PC2:  wb_data_s = PC_plus_2;
      WB_LHI:  wb_data_s = lhi_value(Imm2);
      default: wb_data_s = alu_out;
    endcase
  end

  assign wb_valid = commit_s & RegWrite;
  assign wb_rd    = RD;
  assign wb_data  = wb_data_s;

  reg_file_8x16 u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_valid),
    .wa      (RD),
    .wd      (wb_data_s),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (ra_data),
    .rb_data (rb_data)
  );

  // flag, counter and trace next state; bubbles hold everything
  always_comb begin
    c_flag_d       = c_flag_q;
    z_flag_d       = z_flag_q;
    retire_cnt_d   = retire_cnt_q;
    commit_pc_d    = commit_pc_q;
    commit_store_d = commit_store_q;
    commit_addr_d  = commit_addr_q;
    commit_sdata_d = commit_sdata_q;
    if (commit_s) begin
      if (CWrite) begin
        c_flag_d = carry;
      end else begin
        c_flag_d = c_flag_q;
      end
      case (ZWrite)
        Z_ALU:   z_flag_d = (alu_out == 16'h0000);
        Z_MEM:   z_flag_d = (dm_data == 16'h0000);
        default: z_flag_d = z_flag_q;
      endcase
      retire_cnt_d   = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      commit_pc_d    = PC;
      commit_store_d = S;
      if (S) begin
        commit_addr_d  = mem_addr;
        commit_sdata_d = mem_data;
      end else begin
        commit_addr_d  = commit_addr_q;
        commit_sdata_d = commit_sdata_q;
      end
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // commit state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_flag_q       <= 1'b0;
      z_flag_q       <= 1'b0;
      retire_cnt_q   <= {CNT_W{1'b0}};
      commit_pc_q    <= PC_BUBBLE;
      commit_store_q <= 1'b0;
      commit_addr_q  <= 16'h0000;
      commit_sdata_q <= 16'h0000;
    end else begin
      c_flag_q       <= c_flag_d;
      z_flag_q       <= z_flag_d;
      retire_cnt_q   <= retire_cnt_d;
      commit_pc_q    <= commit_pc_d;
      commit_store_q <= commit_store_d;
      commit_addr_q  <= commit_addr_d;
      commit_sdata_q <= commit_sdata_d;
    end
  end

  assign c_flag       = c_flag_q;
  assign z_flag       = z_flag_q;
  assign retire_cnt   = retire_cnt_q;
  assign commit_pc    = commit_pc_q;
  assign commit_store = commit_store_q;
  assign commit_addr  = commit_addr_q;
  assign commit_sdata = commit_sdata_q;

endmodule

// File: doc/wb_commit.md
# wb_commit

Write-back and commit stage of the 6-stage RISC pipeline, the consumer of the MEM/WB pipeline register outputs. It selects the write-back value and owns the 8×16 architectural register file and the C/Z flag registers. It provides two combinational read ports with write-through bypass to decode, forwarding values to the hazard/forwarding unit, and a retire counter and commit trace for verification.

## Interface
- `NREG`, 8: architectural register count (fixed at 8; 3-bit indices).
- `CNT_W`, 32: retire counter width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `dm_data`, `PC_plus_2`, `alu_out`, `PC`, `mem_data`, `mem_addr` input 16 each: MEM/WB payload.
- `Imm2` input 9: LHI immediate.
- `MemtoReg` input 2: write-back source select.
- `RD` input 3: destination register.
- `L`, `S`, `RegWrite`, `CWrite`, `carry`, `invalid1` input 1 each: load, store, register-write, carry-write, carry value, bubble.
- `ZWrite` input 2: zero-flag source.
- `ra_addr`, `rb_addr` input 3 each: decode read addresses.
- `ra_data`, `rb_data` output 16 each: read data, bypassed.
- `wb_valid` output 1: a register write occurs this cycle.
- `wb_rd` output 3: destination of that write.
- `wb_data` output 16: value of that write (forwarding).
- `c_flag`, `z_flag` output 1 each: architectural flags.
- `retire_cnt` output CNT_W: committed-instruction count.
- `commit_pc` output 16: PC of the last committed instruction.
- `commit_store` output 1: last commit was a store.
- `commit_addr`, `commit_sdata` output 16 each: store address and data of the last store commit.

## Operation
- Commit qualifier: `commit = !invalid1`. Bubbles (`invalid1=1`) change no state.
  - The reset/flush pattern (`PC=16'hb000`, all controls 0) from the upstream register has `invalid1=0` at reset. It therefore counts as a retire only when `invalid1=0`. It never writes a register, because `RegWrite=0`.
- Write-back value by `MemtoReg`:
  - 00: `alu_out`
  - 01: `dm_data`
  - 10: `PC_plus_2`
  - 11: `{Imm2, 7'b0}`
- `wb_valid = commit & RegWrite`. `wb_rd = RD`. `wb_data` is the selected value. All three are combinational.
- Register file: on a rising edge with `wb_valid`, `regs[RD] <= wb_data`. All registers, including R0, are writable.
- Read ports are combinational. If `wb_valid` and the address equals `RD`, the port returns `wb_data` (write-through); otherwise it returns `regs[addr]`.
- Carry flag: on commit with `CWrite=1`, `c_flag <= carry`.
- Zero flag, on commit:
  - `ZWrite` 01: `z_flag <= (alu_out==0)`.
  - `ZWrite` 10: `z_flag <= (dm_data==0)`.
  - `ZWrite` 00 and 11: hold.
- Retire counter: on commit, `retire_cnt` increments by 1 and wraps modulo 2^CNT_W with no saturation.
- Commit trace: on commit, `commit_pc <= PC` and `commit_store <= S`.
  - When `S=1`, also `commit_addr <= mem_addr` and `commit_sdata <= mem_data`. Otherwise those two hold.
- `L` has no effect on state beyond `MemtoReg`. A commit with `L=1` and `MemtoReg!=01` is legal and uses `MemtoReg` as given.
- Simultaneous events: a flag write and a register write in the same cycle are independent. Same-cycle read and write of one register returns the new value.

## Timing
- Asynchronous reset (`rst=0`) immediately clears:
  - all `regs`, `c_flag`, `z_flag`, `retire_cnt`, `commit_store`, `commit_addr`, `commit_sdata` to 0;
  - `commit_pc` to `16'hb000`.
- Reset is released synchronously in use. The first edge after `rst` rises may commit.
- Reset asserted mid-operation discards any pending write. There is no partial state.
- `wb_valid`, `wb_rd`, `wb_data`, `ra_data` and `rb_data` have zero latency, with a combinational path from the inputs.
- `regs`, flags, counter and trace update on the edge that ends the commit cycle and are visible the following cycle.
- There is no handshake and no backpressure. A MEM/WB hold from upstream presents the same instruction again, so it commits once per cycle it is valid. Upstream must present a bubble when stalled.

## Structure
- Shared package: `MemtoReg` encodings (`WB_ALU`, `WB_MEM`, `WB_PC2`, `WB_LHI`), `ZWrite` encodings (`Z_NONE`, `Z_ALU`, `Z_MEM`), and the `PC_BUBBLE=16'hb000` constant. The pipeline-register blocks reuse these.
- One sub-module, `reg_file_8x16`: two read ports with write-through and one write port. Flags, counter and trace live in the top level.

## Test plan
- Reset: assert `rst=0` mid-run → all registers and flags 0, `retire_cnt=0`, `commit_pc=16'hb000`; after release, R3 reads 0.
- ALU write: `MemtoReg=00`, `alu_out=16'h1234`, `RD=5`, `RegWrite=1`, `ZWrite=01`, `CWrite=1`, `carry=1` → `regs[5]=16'h1234`, `z_flag=0`, `c_flag=1`, `retire_cnt`+1.
- Load zero: `MemtoReg=01`, `dm_data=0`, `ZWrite=10`, `RD=2` → `regs[2]=0`, `z_flag=1`. Same cycle, `ra_addr=2` returns 0 (bypass).
- LHI and JAL: `MemtoReg=11`, `Imm2=9'h1FF` → `16'hFF80`. `MemtoReg=10`, `PC_plus_2=16'h0042` → `16'h0042`.
- Bubble: `invalid1=1` with `RegWrite=1`, `CWrite=1`, `ZWrite=01` → no register, flag, counter or trace change; `wb_valid=0`.
- Store and wrap: `S=1`, `mem_addr=16'h0100`, `mem_data=16'hBEEF` → `commit_store=1` with that address and data. Preset `retire_cnt` to all ones, commit → 0.
